syscall_unit: RTL and testbench

//  Parametrised, synthesizable system-call service unit on the execute stage of the MIPS core.

---
 rtl/syscall_pkg.sv | 30 +++
 rtl/syscall_unit_if.sv | 13 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/syscall_unit.sv | 177 +++++++++++++++++
 tb/tb_syscall_unit.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/syscall_pkg.sv
// Shared types and constants for the syscall service unit.
// Service numbers, record kinds and the unit's state encoding.
package syscall_pkg;

    localparam logic [5:0]  FUNCT_SYSCALL  = 6'h0C;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_EXIT2      = 32'd17;
    localparam logic [31:0] SYS_CYCLES     = 32'd30;

    typedef enum logic [1:0] {
        KIND_INT  = 2'b00,
        KIND_CHAR = 2'b01,
        KIND_EXIT = 2'b10
    } out_kind_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    typedef struct packed {
        out_kind_e   kind;
        logic [31:0] data;
    } rec_t;

endpackage

// File: rtl/syscall_unit_if.sv
// Console record stream: valid/ready handshake.
// The unit drives records as master; the sink is slave.
interface syscall_unit_if;

    logic        valid;
    logic        ready;
    logic [1:0]  kind;
    logic [31:0] data;

    modport master (output valid, kind, data, input ready);
    modport slave  (input valid, kind, data, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO, no write-to-read bypass.
// Flags come from the stored count, so a pop never frees a slot early.
module sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];

    // Next storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers; storage cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// Execute-stage SYSCALL service unit: console FIFO, exit/drain/halt,
// cycle and retired-instruction counters, pipeline stall.
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CNT_W        = 64,
    parameter bit          UNKNOWN_HALT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              syscall_control,
    input  logic [31:0]       instruction,
    input  logic              instr_retire,
    input  logic [31:0]       v0,
    input  logic [31:0]       a0,
    output logic              stall,
    syscall_unit_if.master    con,
    output logic              ret_we,
    output logic [31:0]       ret_data,
    output logic              halted,
    output logic [31:0]       exit_code,
    output logic              bad_service,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
);

    rec_t             svc_rec, head;
    logic             svc_push, svc_exit, svc_cyc, svc_bad;
    logic [31:0]      svc_code;
    logic             req, accept, pop;
    logic             fifo_full, fifo_empty;
    state_e           state_q, state_d;
    logic             ret_we_q, ret_we_d, bad_q, bad_d;
    logic [31:0]      ret_data_q, ret_data_d;
    logic [31:0]      exit_code_q, exit_code_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
    logic             unused_instr;

    assign unused_instr = ^instruction[31:6];

    // Decode the requested service from v0.
    always_comb begin
        svc_rec.kind = KIND_INT;
        svc_rec.data = a0;
        svc_push     = 1'b0;
        svc_exit     = 1'b0;
        svc_cyc      = 1'b0;
        svc_bad      = 1'b0;
        svc_code     = 32'd0;
        unique case (1'b1)
            (v0 == SYS_PRINT_INT): begin
                svc_push = 1'b1;
            end
            (v0 == SYS_PRINT_CHAR): begin
                svc_push     = 1'b1;
                svc_rec.kind = KIND_CHAR;
                svc_rec.data = {24'b0, a0[7:0]};
            end
            (v0 == SYS_EXIT): begin
                svc_push     = 1'b1;
                svc_exit     = 1'b1;
                svc_rec.kind = KIND_EXIT;
                svc_rec.data = 32'd0;
            end
            (v0 == SYS_EXIT2): begin
                svc_push     = 1'b1;
                svc_exit     = 1'b1;
                svc_rec.kind = KIND_EXIT;
                svc_code     = a0;
            end
            (v0 == SYS_CYCLES): begin
                svc_cyc = 1'b1;
            end
            default: begin
                svc_bad = 1'b1;
                if (UNKNOWN_HALT) begin
                    svc_push     = 1'b1;
                    svc_exit     = 1'b1;
                    svc_rec.kind = KIND_EXIT;
                    svc_rec.data = 32'hFFFF_FFFF;
                    svc_code     = 32'hFFFF_FFFF;
                end
            end
        endcase
    end

    assign req    = syscall_control
                 && (instruction[5:0] == FUNCT_SYSCALL)
                 && (state_q == ST_RUN);
    assign stall  = (state_q != ST_RUN) || (req && svc_push && fifo_full);
    assign accept = req && !stall;

    sync_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && svc_push),
        .wdata (svc_rec),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign con.valid = !fifo_empty;
    assign con.kind  = head.kind;
    assign con.data  = head.data;
    assign pop       = con.valid && con.ready;

    // Next state, service side effects and counters.
    always_comb begin
        state_d     = state_q;
        ret_we_d    = accept && svc_cyc;
        bad_d       = accept && svc_bad;
        ret_data_d  = ret_data_q;
        exit_code_d = exit_code_q;
        cyc_d       = cyc_q;
        ins_d       = ins_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept && svc_exit) begin
                    state_d     = ST_DRAIN;
                    exit_code_d = svc_code;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        if (accept && svc_cyc) begin
            ret_data_d = cyc_q[31:0];
        end
        if (state_q != ST_HALTED) begin
            cyc_d = cyc_q + CNT_W'(1);
        end
        if ((state_q == ST_RUN) && instr_retire) begin
            ins_d = ins_q + CNT_W'(1);
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ret_we_q    <= 1'b0;
            bad_q       <= 1'b0;
            ret_data_q  <= '0;
            exit_code_q <= '0;
            cyc_q       <= '0;
            ins_q       <= '0;
        end else begin
            state_q     <= state_d;
            ret_we_q    <= ret_we_d;
            bad_q       <= bad_d;
            ret_data_q  <= ret_data_d;
            exit_code_q <= exit_code_d;
            cyc_q       <= cyc_d;
            ins_q       <= ins_d;
        end
    end

    assign ret_we      = ret_we_q;
    assign ret_data    = ret_data_q;
    assign halted      = (state_q == ST_HALTED);
    assign exit_code   = exit_code_q;
    assign bad_service = bad_q;
    assign cycle_count = cyc_q;
    assign instr_count = ins_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: vector table plus
// hand sequences for backpressure, drain/halt, reset and unknown-halt.
module tb_syscall_unit;
    import syscall_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall_control, syscall_control2, instr_retire;
    logic [31:0] instruction, v0, a0;

    logic        stall, ret_we, halted, bad_service;
    logic [31:0] ret_data, exit_code;
    logic [63:0] cycle_count, instr_count;

    logic        stall2, halted2, bad2;
    logic [31:0] exit_code2;
    logic        unused_ret_we2;
    logic [31:0] unused_ret_data2;
    logic [63:0] unused_cyc2, unused_ins2;

    logic [63:0] tb_cyc;
    logic [63:0] frozen;
    int          checks = 0;
    int          errors = 0;

    syscall_unit_if sink ();
    syscall_unit_if sink2 ();

    assign sink2.ready = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= rst ? 64'd0 : tb_cyc + 64'd1;

    syscall_unit #(
        .FIFO_DEPTH(8), .CNT_W(64), .UNKNOWN_HALT(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .syscall_control(syscall_control),
        .instruction(instruction),
        .instr_retire(instr_retire),
        .v0(v0), .a0(a0),
        .stall(stall), .con(sink),
        .ret_we(ret_we), .ret_data(ret_data),
        .halted(halted), .exit_code(exit_code),
        .bad_service(bad_service),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    syscall_unit #(
        .FIFO_DEPTH(8), .CNT_W(64), .UNKNOWN_HALT(1'b1)
    ) dut2 (
        .clk(clk), .rst(rst),
        .syscall_control(syscall_control2),
        .instruction(instruction),
        .instr_retire(instr_retire),
        .v0(v0), .a0(a0),
        .stall(stall2), .con(sink2),
        .ret_we(unused_ret_we2), .ret_data(unused_ret_data2),
        .halted(halted2), .exit_code(exit_code2),
        .bad_service(bad2),
        .cycle_count(unused_cyc2),
        .instr_count(unused_ins2)
    );

    typedef struct {
        logic        ctrl;
        logic [5:0]  funct;
        logic [31:0] v0;
        logic [31:0] a0;
        logic        e_valid;
        logic [1:0]  e_kind;
        logic [31:0] e_data;
        logic        e_ret;
        logic        e_bad;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] sv, input logic [31:0] arg);
        syscall_control = 1'b1;
        instruction     = {26'h0, FUNCT_SYSCALL};
        v0              = sv;
        a0              = arg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 6'h0C, 32'd1,  32'd42,        1'b1, 2'b00, 32'd42,        1'b0, 1'b0};
        vecs[1] = '{1'b1, 6'h0C, 32'd11, 32'h1234_5641, 1'b1, 2'b01, 32'h41,        1'b0, 1'b0};
        vecs[2] = '{1'b1, 6'h0C, 32'd1,  32'hFFFF_FFFF, 1'b1, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'h0C, 32'd5,  32'd3,         1'b0, 2'b00, 32'd0,         1'b0, 1'b1};
        vecs[4] = '{1'b1, 6'h0C, 32'd30, 32'd0,         1'b0, 2'b00, 32'd0,         1'b1, 1'b0};
        vecs[5] = '{1'b1, 6'h0D, 32'd1,  32'd9,         1'b0, 2'b00, 32'd0,         1'b0, 1'b0};
        vecs[6] = '{1'b0, 6'h0C, 32'd1,  32'd9,         1'b0, 2'b00, 32'd0,         1'b0, 1'b0};
        vecs[7] = '{1'b1, 6'h0C, 32'd11, 32'h0000_00FF, 1'b1, 2'b01, 32'hFF,        1'b0, 1'b0};

        rst = 1'b1;
        syscall_control  = 1'b0;
        syscall_control2 = 1'b0;
        instr_retire     = 1'b0;
        instruction      = 32'd0;
        v0               = 32'd0;
        a0               = 32'd0;
        sink.ready       = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_valid", sink.valid, 0);
        chk("rst_ret_we", ret_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_bad", bad_service, 0);
        chk("rst_exit_code", exit_code, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_instrs", instr_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // retired instruction counter
        repeat (3) begin
            @(negedge clk);
            instr_retire = 1'b1;
        end
        @(negedge clk);
        instr_retire = 1'b0;
        #1;
        chk("instr_count", instr_count, 3);

        // cycle-count service at cycle 100
        while (tb_cyc != 64'd100) @(negedge clk);
        chk("cycles_at_100", cycle_count, 100);
        issue(SYS_CYCLES, 32'd0);
        #1;
        chk("cyc_svc_stall", stall, 0);
        @(negedge clk);
        syscall_control = 1'b0;
        #1;
        chk("cyc_ret_we", ret_we, 1);
        chk("cyc_ret_data", ret_data, 100);
        chk("cyc_no_push", sink.valid, 0);
        @(negedge clk);
        #1;
        chk("cyc_ret_we_pulse", ret_we, 0);

        // single-service vector table, sink always ready
        sink.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            syscall_control = vecs[i].ctrl;
            instruction     = {26'h3, vecs[i].funct};
            v0              = vecs[i].v0;
            a0              = vecs[i].a0;
            #1;
            chk($sformatf("vec%0d_stall", i), stall, 0);
            chk($sformatf("vec%0d_idle", i), sink.valid, 0);
            @(negedge clk);
            syscall_control = 1'b0;
            #1;
            chk($sformatf("vec%0d_valid", i), sink.valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_kind", i), sink.kind, vecs[i].e_kind);
                chk($sformatf("vec%0d_data", i), sink.data, vecs[i].e_data);
            end
            chk($sformatf("vec%0d_ret_we", i), ret_we, vecs[i].e_ret);
            chk($sformatf("vec%0d_bad", i), bad_service, vecs[i].e_bad);
        end
        @(negedge clk);
        #1;
        chk("table_fifo_empty", sink.valid, 0);

        // backpressure: 9 prints into an 8-deep FIFO
        sink.ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            issue(SYS_PRINT_INT, k);
            #1;
            chk($sformatf("fill%0d_stall", k), stall, (k == 8));
        end
        @(negedge clk);
        #1;
        chk("full_stall_hold", stall, 1);
        chk("full_head_stable", sink.data, 0);
        @(negedge clk);
        sink.ready = 1'b1;
        #1;
        chk("full_pop_stall", stall, 1);
        chk("full_pop_head", sink.data, 0);
        @(negedge clk);
        sink.ready = 1'b0;
        #1;
        chk("after_pop_accept", stall, 0);
        @(negedge clk);
        syscall_control = 1'b0;
        for (int j = 1; j < 9; j++) begin
            sink.ready = 1'b1;
            #1;
            chk($sformatf("drain%0d_valid", j), sink.valid, 1);
            chk($sformatf("drain%0d_data", j), sink.data, j);
            @(negedge clk);
        end
        #1;
        chk("drain_empty", sink.valid, 0);

        // exit with 3 records queued
        sink.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            issue(SYS_PRINT_INT, 100 + k);
        end
        @(negedge clk);
        issue(SYS_EXIT2, 32'd7);
        #1;
        chk("exit_accept_stall", stall, 0);
        @(negedge clk);
        syscall_control = 1'b0;
        instr_retire    = 1'b1;
        #1;
        chk("drain_stall", stall, 1);
        chk("drain_not_halted", halted, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            sink.ready = 1'b1;
            #1;
            chk($sformatf("exq%0d_data", j), sink.data, 100 + j);
        end
        @(negedge clk);
        #1;
        chk("exit_rec_valid", sink.valid, 1);
        chk("exit_rec_kind", sink.kind, KIND_EXIT);
        chk("exit_rec_data", sink.data, 7);
        @(negedge clk);
        #1;
        chk("exit_drained", sink.valid, 0);
        chk("exit_halt_wait", halted, 0);
        @(negedge clk);
        #1;
        chk("halted", halted, 1);
        chk("exit_code", exit_code, 7);
        chk("halted_stall", stall, 1);
        chk("halt_cycles", cycle_count, tb_cyc);
        frozen = tb_cyc;
        repeat (3) @(negedge clk);
        #1;
        chk("cycles_frozen", cycle_count, frozen);
        chk("instrs_frozen", instr_count, 3);
        instr_retire = 1'b0;

        // reset during drain with records queued
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sink.ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            issue(SYS_PRINT_INT, 200 + k);
        end
        @(negedge clk);
        issue(SYS_EXIT2, 32'd9);
        @(negedge clk);
        syscall_control = 1'b0;
        #1;
        chk("r6_drain_stall", stall, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("r6_valid", sink.valid, 0);
        chk("r6_stall", stall, 0);
        chk("r6_halted", halted, 0);
        chk("r6_cycles", cycle_count, 0);
        chk("r6_instrs", instr_count, 0);
        chk("r6_exit_code", exit_code, 0);
        @(negedge clk);
        issue(SYS_PRINT_INT, 32'd55);
        sink.ready = 1'b1;
        #1;
        chk("r6_run_accept", stall, 0);
        @(negedge clk);
        syscall_control = 1'b0;
        #1;
        chk("r6_new_valid", sink.valid, 1);
        chk("r6_new_data", sink.data, 55);
        @(negedge clk);
        #1;
        chk("r6_new_empty", sink.valid, 0);

        // unknown service on the halting variant
        @(negedge clk);
        v0               = 32'd5;
        a0               = 32'd0;
        instruction      = {26'h0, FUNCT_SYSCALL};
        syscall_control2 = 1'b1;
        #1;
        chk("u_accept_stall", stall2, 0);
        @(negedge clk);
        syscall_control2 = 1'b0;
        #1;
        chk("u_bad", bad2, 1);
        chk("u_valid", sink2.valid, 1);
        chk("u_kind", sink2.kind, KIND_EXIT);
        chk("u_data", sink2.data, 32'hFFFF_FFFF);
        chk("u_drain_stall", stall2, 1);
        @(negedge clk);
        #1;
        chk("u_empty", sink2.valid, 0);
        chk("u_bad_pulse", bad2, 0);
        @(negedge clk);
        #1;
        chk("u_halted", halted2, 1);
        chk("u_exit_code", exit_code2, 32'hFFFF_FFFF);
        chk("main_not_halted", halted, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
